// File: rtl/code_sequencer_3b_pkg.sv
// Shared types and the code-step helper for the 3-bit code sequencer
// and its pushbutton debouncer.
package seg_pkg;

  localparam int CODE_W = 3;

  typedef logic [CODE_W-1:0] code_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    PRESSED = 2'd2,
    DISARM  = 2'd3
  } deb_state_t;

  typedef struct packed {
    code_t code;
    logic  wrap;
  } step_t;

  // One step up or down inside 0..max_code; an out-of-range code is pulled back in.
  function automatic step_t step_code(input code_t cur, input logic up, input code_t max_code);
    step_t res;
    res.code = cur;
    res.wrap = 1'b0;
    if (up) begin
      if (cur >= max_code) begin
        res.code = {CODE_W{1'b0}};
        res.wrap = 1'b1;
      end else begin
        res.code = cur + code_t'(1);
      end
    end else begin
      if (cur == {CODE_W{1'b0}}) begin
        res.code = max_code;
        res.wrap = 1'b1;
      end else if (cur > max_code) begin
        res.code = max_code;
      end else begin
        res.code = cur - code_t'(1);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/code_sequencer_3b_btn_debounce.sv
// Pushbutton synchroniser and debounce FSM; emits a one-clock step_req when
// a press has been held high for DEB_CYCLES consecutive synchronised cycles.
module btn_debounce
  import seg_pkg::*;
#(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_step,
  output logic step_req
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             r_sync_meta;
  logic             r_sync;
  deb_state_t       r_state;
  deb_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_req;

  // Two-flop synchroniser for the raw button.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_meta <= 1'b0;
      r_sync      <= 1'b0;
    end else begin
      r_sync_meta <= btn_step;
      r_sync      <= r_sync_meta;
    end
  end

  // State and level-duration counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= CNT_ZERO;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state, counter and the request strobe, issued on the ARM->PRESSED edge.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_req       = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = CNT_ZERO;
        if (r_sync) begin
          w_state_nxt = ARM;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ARM: begin
        if (!r_sync) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = CNT_ZERO;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = PRESSED;
          w_cnt_nxt   = CNT_ZERO;
          w_req       = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      PRESSED: begin
        w_cnt_nxt = CNT_ZERO;
        if (!r_sync) begin
          w_state_nxt = DISARM;
        end else begin
          w_state_nxt = PRESSED;
        end
      end
      DISARM: begin
        // A bounce back high during release is the same press, not a new one.
        if (r_sync) begin
          w_state_nxt = PRESSED;
          w_cnt_nxt   = CNT_ZERO;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = CNT_ZERO;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = CNT_ZERO;
      end
    endcase
  end

  assign step_req = w_req;

endmodule

// File: rtl/code_sequencer_3b.sv
// Registered 3-bit code {A,B,C} stepped by a debounced pushbutton.
// Optional timed auto-step divider is built when AUTO_STEP_EN is defined.
module code_sequencer_3b
  import seg_pkg::*;
#(
  parameter int DEB_CYCLES = 16,
  parameter int MAX_CODE   = 7
`ifdef AUTO_STEP_EN
  ,
  parameter int STEP_DIV   = 8
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_step,
  input  logic dir_up,
  input  logic hold,
`ifdef AUTO_STEP_EN
  input  logic auto_mode,
`endif
  output logic A,
  output logic B,
  output logic C,
  output logic step_pulse,
  output logic wrap
);

  localparam code_t MAX_C = code_t'(MAX_CODE);

  logic  r_dir_meta;
  logic  r_dir_sync;
  logic  r_hold_meta;
  logic  r_hold_sync;
  code_t r_code;
  logic  r_step;
  logic  r_wrap;
  logic  w_btn_req;
  logic  w_req;
  step_t w_step;

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_btn_debounce (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_step (btn_step),
    .step_req (w_btn_req)
  );

  // Two-flop synchronisers for the direction and hold levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dir_meta  <= 1'b0;
      r_dir_sync  <= 1'b0;
      r_hold_meta <= 1'b0;
      r_hold_sync <= 1'b0;
    end else begin
      r_dir_meta  <= dir_up;
      r_dir_sync  <= r_dir_meta;
      r_hold_meta <= hold;
      r_hold_sync <= r_hold_meta;
    end
  end

`ifdef AUTO_STEP_EN
  localparam int DIV_W = $clog2(STEP_DIV);
  localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);

  logic             r_auto_meta;
  logic             r_auto_sync;
  logic [DIV_W-1:0] r_div;
  logic             w_div_run;
  logic             w_div_req;

  // Two-flop synchroniser for the auto-mode level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_auto_meta <= 1'b0;
      r_auto_sync <= 1'b0;
    end else begin
      r_auto_meta <= auto_mode;
      r_auto_sync <= r_auto_meta;
    end
  end

  assign w_div_run = r_auto_sync & ~r_hold_sync;
  assign w_div_req = w_div_run & (r_div == DIV_LAST);

  // Auto-step divider: counts 0..STEP_DIV-1 while running, otherwise held cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= DIV_ZERO;
    end else if (!w_div_run) begin
      r_div <= DIV_ZERO;
    end else if (r_div == DIV_LAST) begin
      r_div <= DIV_ZERO;
    end else begin
      r_div <= r_div + DIV_ONE;
    end
  end

  // Coincident button and divider requests merge into one step.
  assign w_req = w_btn_req | w_div_req;
`else
  assign w_req = w_btn_req;
`endif

  // Candidate next code and wrap flag for the current direction.
  always_comb begin
    w_step = step_code(r_code, r_dir_sync, MAX_C);
  end

  // Code register with coincident step and wrap strobes; hold drops requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_code <= {CODE_W{1'b0}};
      r_step <= 1'b0;
      r_wrap <= 1'b0;
    end else if (w_req && !r_hold_sync) begin
      r_code <= w_step.code;
      r_step <= 1'b1;
      r_wrap <= w_step.wrap;
    end else begin
      r_step <= 1'b0;
      r_wrap <= 1'b0;
    end
  end

  assign A          = r_code[2];
  assign B          = r_code[1];
  assign C          = r_code[0];
  assign step_pulse = r_step;
  assign wrap       = r_wrap;

endmodule
